// File: rtl/key_encoder_binary_param_pkg.sv
// Shared types for the binary key encoder: FSM states and keypad bit indices.
package key_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } key_state_t;

  localparam int KEY_ONE  = 1;
  localparam int KEY_ZERO = 0;

endpackage

// File: rtl/key_encoder_binary_param_if.sv
// Keypad-side and consumer-side signals of the binary key encoder.
interface key_encoder_binary_param_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       keypad;
  logic             clear;
  logic [WIDTH-1:0] keycode;
  logic [CNT_W-1:0] digit_count;
  logic             key_strobe;
  logic             move_on;

  modport master (
    output keypad, clear,
    input  keycode, digit_count, key_strobe, move_on
  );

  modport slave (
    input  keypad, clear,
    output keycode, digit_count, key_strobe, move_on
  );

endinterface

// File: rtl/key_encoder_binary_param_debouncer.sv
// One keypad line: 2-FF synchroniser, optional hold-time filter, rising-edge detect.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic level_q;

  // Stage 0/1: metastability synchroniser
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      assign level = sync_p1;
    end else begin : g_filt
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt_p2;
      logic          level_p2;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          cnt_p2   <= '0;
          level_p2 <= 1'b0;
        end else if (sync_p1 == level_p2) begin
          cnt_p2 <= '0;
        end else if (cnt_p2 == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_p2   <= '0;
          level_p2 <= sync_p1;
        end else begin
          cnt_p2 <= cnt_p2 + CW'(1);
        end
      end

      assign level = level_p2;
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/key_encoder_binary_param.sv
// Two-button binary key entry: shifts accepted "1"/"0" presses MSB-first into a WIDTH-bit code.
module key_encoder_binary_param
  import key_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = $clog2(WIDTH + 1)
) (
  input logic                       clk,
  input logic                       nrst,
  key_encoder_binary_param_if.slave kif
);

  logic       level_one, rise_one;
  logic       level_zero, rise_zero;
  logic       ev_one, ev_zero, ev;
  key_state_t state_q;

  logic [WIDTH-1:0] keycode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic             strobe_q;
  logic             move_q;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] code, input logic b);
    return {code[WIDTH-2:0], b};
  endfunction

  function automatic logic [WIDTH-1:0] fresh_code(input logic b);
    logic [WIDTH-1:0] r;
    r    = '0;
    r[0] = b;
    return r;
  endfunction

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_one (
    .clk    (clk),
    .nrst   (nrst),
    .raw_in (kif.keypad[KEY_ONE]),
    .level  (level_one),
    .rise   (rise_one)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_zero (
    .clk    (clk),
    .nrst   (nrst),
    .raw_in (kif.keypad[KEY_ZERO]),
    .level  (level_zero),
    .rise   (rise_zero)
  );

  // A press only counts while the other key is released, which also rejects simultaneous rises
  assign ev_one    = rise_one & ~level_zero;
  assign ev_zero   = rise_zero & ~level_one;
  assign ev        = ev_one | ev_zero;
  assign count_inc = count_q + CNT_W'(1);

  // Stage 3: FSM, shift register and digit counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= COLLECT;
      keycode_q <= '0;
      count_q   <= '0;
      strobe_q  <= 1'b0;
      move_q    <= 1'b0;
    end else if (kif.clear) begin
      state_q   <= COLLECT;
      keycode_q <= '0;
      count_q   <= '0;
      strobe_q  <= 1'b0;
      move_q    <= 1'b0;
    end else if (ev) begin
      strobe_q <= 1'b1;
      case (state_q)
        COLLECT: begin
          keycode_q <= shift_in(keycode_q, ev_one);
          count_q   <= count_inc;
          if (count_inc == CNT_W'(WIDTH)) begin
            move_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            move_q  <= 1'b0;
          end
        end
        default: begin
          keycode_q <= fresh_code(ev_one);
          count_q   <= CNT_W'(1);
          move_q    <= 1'b0;
          state_q   <= COLLECT;
        end
      endcase
    end else begin
      strobe_q <= 1'b0;
      move_q   <= 1'b0;
    end
  end

  assign kif.keycode     = keycode_q;
  assign kif.digit_count = count_q;
  assign kif.key_strobe  = strobe_q;
  assign kif.move_on     = move_q;

endmodule

// File: tb/tb_key_encoder_binary_param.sv
// Directed bench for key_encoder_binary_param: 4-bit, 4-bit debounced and 8-bit instances.
module tb_key_encoder_binary_param;

  logic tb_clk;
  logic nrst;
  int   checks;
  int   failures;

  key_encoder_binary_param_if #(.WIDTH(4)) if4 ();
  key_encoder_binary_param_if #(.WIDTH(4)) ifdb ();
  key_encoder_binary_param_if #(.WIDTH(8)) if8 ();

  key_encoder_binary_param #(.WIDTH(4), .DEBOUNCE_CYCLES(0)) dut4 (
    .clk (tb_clk), .nrst (nrst), .kif (if4)
  );
  key_encoder_binary_param #(.WIDTH(4), .DEBOUNCE_CYCLES(3)) dutdb (
    .clk (tb_clk), .nrst (nrst), .kif (ifdb)
  );
  key_encoder_binary_param #(.WIDTH(8), .DEBOUNCE_CYCLES(0)) dut8 (
    .clk (tb_clk), .nrst (nrst), .kif (if8)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Advance n rising edges and settle just past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // Press a key on the 4-bit instance, wait out the 3-edge latency, then release fully
  task automatic press4(input logic b);
    if4.keypad = b ? 2'b10 : 2'b01;
    tick(3);
    if4.keypad = 2'b00;
    tick(3);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    tick(2);
    checks++;
    if (if4.keycode !== 4'b0000) begin
      failures++; $display("FAIL reset_keycode got=%b want=0000", if4.keycode);
    end
    checks++;
    if (if4.digit_count !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d want=0", if4.digit_count);
    end
    checks++;
    if (if4.key_strobe !== 1'b0 || if4.move_on !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%b%b want=00", if4.key_strobe, if4.move_on);
    end
    checks++;
    if (if8.keycode !== 8'h00 || ifdb.keycode !== 4'h0) begin
      failures++; $display("FAIL reset_others got=%h/%h want=00/0", if8.keycode, ifdb.keycode);
    end
    nrst = 1'b1;
    tick(1);
  endtask

  task automatic test_first_bit;
    if4.keypad = 2'b10;
    tick(2);
    checks++;
    if (if4.key_strobe !== 1'b0 || if4.digit_count !== 3'd0) begin
      failures++; $display("FAIL t1_early got=%b/%0d want=0/0", if4.key_strobe, if4.digit_count);
    end
    tick(1);
    checks++;
    if (if4.keycode !== 4'b0001 || if4.digit_count !== 3'd1) begin
      failures++; $display("FAIL t1_code got=%b/%0d want=0001/1", if4.keycode, if4.digit_count);
    end
    checks++;
    if (if4.key_strobe !== 1'b1 || if4.move_on !== 1'b0) begin
      failures++; $display("FAIL t1_pulses got=%b%b want=10", if4.key_strobe, if4.move_on);
    end
    if4.keypad = 2'b00;
    tick(1);
    checks++;
    if (if4.key_strobe !== 1'b0) begin
      failures++; $display("FAIL t1_strobe_len got=%b want=0", if4.key_strobe);
    end
    tick(2);
    if4.clear = 1'b1;
    tick(1);
    if4.clear = 1'b0;
    checks++;
    if (if4.keycode !== 4'b0000 || if4.digit_count !== 3'd0) begin
      failures++; $display("FAIL t1_clear got=%b/%0d want=0000/0", if4.keycode, if4.digit_count);
    end
  endtask

  task automatic test_sequence;
    logic [3:0] seq;
    seq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      if4.keypad = seq[3-i] ? 2'b10 : 2'b01;
      tick(3);
      checks++;
      if (if4.key_strobe !== 1'b1 || if4.move_on !== (i == 3)) begin
        failures++;
        $display("FAIL t2_press%0d got=%b%b want=1%b", i, if4.key_strobe, if4.move_on, (i == 3));
      end
      if4.keypad = 2'b00;
      tick(1);
      checks++;
      if (if4.key_strobe !== 1'b0 || if4.move_on !== 1'b0) begin
        failures++; $display("FAIL t2_pulse_len%0d got=%b%b want=00", i, if4.key_strobe, if4.move_on);
      end
      tick(2);
    end
    checks++;
    if (if4.keycode !== 4'b1011 || if4.digit_count !== 3'd4) begin
      failures++; $display("FAIL t2_full got=%b/%0d want=1011/4", if4.keycode, if4.digit_count);
    end
    if4.keypad = 2'b01;
    tick(3);
    checks++;
    if (if4.keycode !== 4'b0000 || if4.digit_count !== 3'd1) begin
      failures++; $display("FAIL t2_restart got=%b/%0d want=0000/1", if4.keycode, if4.digit_count);
    end
    checks++;
    if (if4.key_strobe !== 1'b1 || if4.move_on !== 1'b0) begin
      failures++; $display("FAIL t2_restart_pulses got=%b%b want=10", if4.key_strobe, if4.move_on);
    end
    if4.keypad = 2'b00;
    tick(3);
  endtask

  task automatic test_simultaneous;
    int strobes;
    strobes = 0;
    if4.keypad = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (if4.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || if4.keycode !== 4'b0000 || if4.digit_count !== 3'd1) begin
      failures++;
      $display("FAIL t3_both strobes=%0d got=%b/%0d want 0 strobes 0000/1", strobes, if4.keycode, if4.digit_count);
    end
    if4.keypad = 2'b00;
    tick(3);
    if4.keypad = 2'b10;
    tick(3);
    checks++;
    if (if4.keycode !== 4'b0001 || if4.digit_count !== 3'd2) begin
      failures++; $display("FAIL t3_one got=%b/%0d want=0001/2", if4.keycode, if4.digit_count);
    end
    tick(2);
    strobes = 0;
    if4.keypad = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (if4.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || if4.keycode !== 4'b0001 || if4.digit_count !== 3'd2) begin
      failures++;
      $display("FAIL t3_held strobes=%0d got=%b/%0d want 0 strobes 0001/2", strobes, if4.keycode, if4.digit_count);
    end
    if4.keypad = 2'b00;
    tick(3);
  endtask

  task automatic test_clear_event;
    int strobes;
    if4.clear = 1'b1;
    tick(1);
    if4.clear = 1'b0;
    press4(1'b1);
    press4(1'b1);
    checks++;
    if (if4.keycode !== 4'b0011 || if4.digit_count !== 3'd2) begin
      failures++; $display("FAIL t5_pre got=%b/%0d want=0011/2", if4.keycode, if4.digit_count);
    end
    if4.keypad = 2'b10;
    tick(2);
    if4.clear = 1'b1;
    tick(1);
    if4.clear = 1'b0;
    checks++;
    if (if4.keycode !== 4'b0000 || if4.digit_count !== 3'd0 ||
        if4.key_strobe !== 1'b0 || if4.move_on !== 1'b0) begin
      failures++;
      $display("FAIL t5_clear got=%b/%0d/%b%b want=0000/0/00", if4.keycode, if4.digit_count,
               if4.key_strobe, if4.move_on);
    end
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (if4.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || if4.digit_count !== 3'd0) begin
      failures++; $display("FAIL t5_refire strobes=%0d count=%0d want=0/0", strobes, if4.digit_count);
    end
    if4.keypad = 2'b00;
    tick(3);
  endtask

  task automatic test_reset_mid;
    press4(1'b1);
    press4(1'b0);
    checks++;
    if (if4.digit_count !== 3'd2 || if4.keycode !== 4'b0010) begin
      failures++; $display("FAIL t6_pre got=%b/%0d want=0010/2", if4.keycode, if4.digit_count);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (if4.keycode !== 4'b0000 || if4.digit_count !== 3'd0 ||
        if4.key_strobe !== 1'b0 || if4.move_on !== 1'b0) begin
      failures++;
      $display("FAIL t6_async_reset got=%b/%0d/%b%b want=0000/0/00", if4.keycode, if4.digit_count,
               if4.key_strobe, if4.move_on);
    end
    tick(1);
    nrst = 1'b1;
    tick(1);
  endtask

  task automatic test_debounce;
    int strobes;
    int first_edge;
    strobes = 0;
    ifdb.keypad = 2'b10;
    tick(2);
    ifdb.keypad = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ifdb.key_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || ifdb.digit_count !== 3'd0) begin
      failures++; $display("FAIL t4_glitch strobes=%0d count=%0d want=0/0", strobes, ifdb.digit_count);
    end
    strobes    = 0;
    first_edge = 0;
    ifdb.keypad = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (ifdb.key_strobe === 1'b1) begin
        strobes++;
        if (first_edge == 0) first_edge = i;
      end
    end
    checks++;
    if (strobes != 1 || first_edge != 6) begin
      failures++; $display("FAIL t4_press strobes=%0d edge=%0d want=1/6", strobes, first_edge);
    end
    checks++;
    if (ifdb.keycode !== 4'b0001 || ifdb.digit_count !== 3'd1) begin
      failures++; $display("FAIL t4_code got=%b/%0d want=0001/1", ifdb.keycode, ifdb.digit_count);
    end
    ifdb.keypad = 2'b00;
    tick(8);
  endtask

  task automatic test_width8;
    logic [7:0] seq;
    int moves;
    int move_at;
    seq     = 8'b10110010;
    moves   = 0;
    move_at = -1;
    for (int i = 0; i < 8; i++) begin
      if8.keypad = seq[7-i] ? 2'b10 : 2'b01;
      tick(3);
      if (if8.key_strobe !== 1'b1) begin
        checks++;
        failures++; $display("FAIL t6_w8_strobe%0d got=%b want=1", i, if8.key_strobe);
      end
      if (if8.move_on === 1'b1) begin moves++; move_at = i; end
      if8.keypad = 2'b00;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        if (if8.move_on === 1'b1) moves++;
      end
    end
    checks++;
    if (moves != 1 || move_at != 7) begin
      failures++; $display("FAIL t6_w8_move count=%0d at=%0d want=1/7", moves, move_at);
    end
    checks++;
    if (if8.keycode !== 8'hB2 || if8.digit_count !== 4'd8) begin
      failures++; $display("FAIL t6_w8_code got=%h/%0d want=b2/8", if8.keycode, if8.digit_count);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    nrst        = 1'b0;
    if4.keypad  = 2'b00; if4.clear  = 1'b0;
    ifdb.keypad = 2'b00; ifdb.clear = 1'b0;
    if8.keypad  = 2'b00; if8.clear  = 1'b0;
    test_reset();
    test_first_bit();
    test_sequence();
    test_simultaneous();
    test_clear_event();
    test_reset_mid();
    test_debounce();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
